// File: rtl/y86_defs.sv
// y86_defs: shared Y86-64 definitions for the pipeline slice.
//   - instruction codes (icode field)
//   - pipeline status codes
//   - "no register" encoding
//   - helpers that classify which icodes read or write data memory
package y86_defs;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [2:0] AOK = 3'd1;
   localparam logic [2:0] HLT = 3'd2;
   localparam logic [2:0] ADR = 3'd3;
   localparam logic [2:0] INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   function automatic logic isMemRead(input logic [3:0] icode);
      return (icode == MRMOVQ) || (icode == POPQ) || (icode == RET);
   endfunction

   function automatic logic isMemWrite(input logic [3:0] icode);
      return (icode == RMMOVQ) || (icode == PUSHQ) || (icode == CALL);
   endfunction

endpackage

// File: rtl/data_memory.sv
// data_memory: byte-addressed data memory for the Y86-64 memory stage.
//   clk      in   clock; writes and preloads commit on the rising edge
//   rst_n    in   active-low reset; a pipeline write is dropped while low
//   addr     in   64-bit byte address of the 8-byte access
//   rdReq    in   access is a read
//   wrReq    in   access is a write
//   wrAllow  in   pipeline permits the write to commit (exception gating)
//   wrData   in   8-byte write data, stored little-endian
//   ldEn     in   preload enable (loader/bench use)
//   ldAddr   in   preload byte address
//   ldData   in   preload byte
//   rdData   out  combinational 8-byte little-endian read, 0 when idle/error
//   memError out  read or write reaches beyond the last full word
// The array itself is never reset.
module data_memory #(
   parameter int DMEM_BYTES = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] addr,
   input  logic        rdReq,
   input  logic        wrReq,
   input  logic        wrAllow,
   input  logic [63:0] wrData,
   input  logic        ldEn,
   input  logic [63:0] ldAddr,
   input  logic [7:0]  ldData,
   output logic [63:0] rdData,
   output logic        memError
);

   localparam int          AW        = $clog2(DMEM_BYTES);
   // Highest address at which a full 8-byte word still fits.
   localparam logic [63:0] LAST_WORD = 64'(DMEM_BYTES - 8);
   localparam logic [63:0] MEM_SIZE  = 64'(DMEM_BYTES);

   logic [7:0]    mem [DMEM_BYTES];
   logic [AW-1:0] baseIdx;
   logic [AW-1:0] ldIdx;
   logic          wrEn;
   logic          ldOk;

   // Comparing the base address against LAST_WORD (instead of checking
   // addr+7) keeps addresses near 2^64 from wrapping into range.
   assign memError = (rdReq | wrReq) && (addr > LAST_WORD);

   assign baseIdx = addr[AW-1:0];
   assign ldIdx   = ldAddr[AW-1:0];

   // rst_n is sampled as a plain enable so a write coinciding with reset
   // is discarded rather than half-committed.
   assign wrEn = wrReq & wrAllow & ~memError & rst_n;
   assign ldOk = ldEn && (ldAddr < MEM_SIZE);

   always_comb begin
      rdData = '0;
      if (rdReq && !memError) begin
         for (int i = 0; i < 8; i++) begin
            rdData[8*i +: 8] = mem[baseIdx + AW'(i)];
         end
      end
   end

   // The pipeline write follows the preload so that, on a byte collision,
   // the later non-blocking assignment (pipeline data) takes effect.
   always_ff @(posedge clk) begin
      if (ldOk) begin
         mem[ldIdx] <= ldData;
      end
      if (wrEn) begin
         for (int i = 0; i < 8; i++) begin
            mem[baseIdx + AW'(i)] <= wrData[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: Y86-64 memory stage plus the M->W pipeline register.
//   clk, rst_n     clock; asynchronous active-low reset
//   M_stat/icode/valE/valA/dstE/dstM   in   fields from the M register
//   W_stall        in   hold the W register
//   ld_en/ld_addr/ld_data              in   data-memory preload port
//   m_stat, m_valM out  combinational memory-stage status and read data
//   W_stat/icode/valE/valM/dstE/dstM   out  registered W-stage fields
//   proc_halt      out  sticky flag: W_stat has left AOK since reset
module mem_wb_stage
   import y86_defs::*;
#(
   parameter int DMEM_BYTES = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        ld_en,
   input  logic [63:0] ld_addr,
   input  logic [7:0]  ld_data,
   output logic [2:0]  m_stat,
   output logic [63:0] m_valM,
   output logic [2:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic        proc_halt
);

   logic [63:0] memAddr;
   logic        memRead;
   logic        memWrite;
   logic        memError;
   logic        wrAllow;
   logic [63:0] rdData;
   logic [2:0]  wNextStat;

   // popq and ret read through the old stack pointer carried in valA;
   // pushq and call write at the decremented pointer computed into valE.
   always_comb begin
      memAddr = '0;
      case (M_icode)
         RMMOVQ, MRMOVQ, PUSHQ, CALL: memAddr = M_valE;
         POPQ, RET:                   memAddr = M_valA;
         default:                     memAddr = '0;
      endcase
   end

   assign memRead  = isMemRead(M_icode);
   assign memWrite = isMemWrite(M_icode);

   // Once anything ahead of, or this instruction itself, is exceptional,
   // memory must stay untouched so the architectural state is precise.
   assign wrAllow = (M_stat == AOK) && (W_stat == AOK) && !proc_halt;

   data_memory #(
      .DMEM_BYTES(DMEM_BYTES)
   ) uDmem (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (memAddr),
      .rdReq   (memRead),
      .wrReq   (memWrite),
      .wrAllow (wrAllow),
      .wrData  (M_valA),
      .ldEn    (ld_en),
      .ldAddr  (ld_addr),
      .ldData  (ld_data),
      .rdData  (rdData),
      .memError(memError)
   );

   assign m_stat = memError ? ADR : M_stat;
   assign m_valM = rdData;

   // Status W will hold after this edge; drives the sticky halt flag
   // independent of stalling.
   assign wNextStat = W_stall ? W_stat : m_stat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         W_stat  <= AOK;
         W_icode <= NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
      end else if (!W_stall) begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proc_halt <= 1'b0;
      end else if (wNextStat != AOK) begin
         proc_halt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clk;
   logic        rst_n;
   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;
   logic        W_stall;
   logic        ld_en;
   logic [63:0] ld_addr;
   logic [7:0]  ld_data;
   logic [2:0]  m_stat;
   logic [63:0] m_valM;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode;
   logic [63:0] W_valE;
   logic [63:0] W_valM;
   logic [3:0]  W_dstE;
   logic [3:0]  W_dstM;
   logic        proc_halt;

   int cmpCnt = 0;
   int errCnt = 0;

   mem_wb_stage #(.DMEM_BYTES(8192)) dut (
      .clk(clk), .rst_n(rst_n),
      .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .m_stat(m_stat), .m_valM(m_valM),
      .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
      .W_dstE(W_dstE), .W_dstM(W_dstM), .proc_halt(proc_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] vE,
                        input logic [63:0] vA, input logic [3:0] dE, input logic [3:0] dM);
      M_stat = st; M_icode = ic; M_valE = vE; M_valA = vA; M_dstE = dE; M_dstM = dM;
      #1;
   endtask

   task automatic set_idle();
      set_m(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
   endtask

   task automatic load_byte(input logic [63:0] a, input logic [7:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   task automatic reset_dut();
      set_idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      set_m(3'd1, 4'h6, 64'h77, 64'h0, 4'h2, 4'hF);
      step(); step();
      cmpCnt++; if (W_icode !== 4'h6) begin errCnt++; $display("FAIL pre_rst_icode: got %h want %h", W_icode, 4'h6); end
      #3;
      rst_n = 1'b0;
      #1;
      cmpCnt++; if (W_icode !== 4'h1) begin errCnt++; $display("FAIL rst_icode: got %h want %h", W_icode, 4'h1); end
      cmpCnt++; if (W_stat !== 3'd1) begin errCnt++; $display("FAIL rst_stat: got %h want %h", W_stat, 3'd1); end
      cmpCnt++; if (W_dstE !== 4'hF) begin errCnt++; $display("FAIL rst_dstE: got %h want %h", W_dstE, 4'hF); end
      cmpCnt++; if (W_dstM !== 4'hF) begin errCnt++; $display("FAIL rst_dstM: got %h want %h", W_dstM, 4'hF); end
      cmpCnt++; if (W_valE !== 64'h0) begin errCnt++; $display("FAIL rst_valE: got %h want %h", W_valE, 64'h0); end
      cmpCnt++; if (W_valM !== 64'h0) begin errCnt++; $display("FAIL rst_valM: got %h want %h", W_valM, 64'h0); end
      cmpCnt++; if (proc_halt !== 1'b0) begin errCnt++; $display("FAIL rst_halt: got %b want %b", proc_halt, 1'b0); end
      set_idle();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_write_read();
      load_byte(64'h108, 8'h99);
      set_m(3'd1, 4'h4, 64'h100, 64'h1122334455667788, 4'hF, 4'hF);
      cmpCnt++; if (m_stat !== 3'd1) begin errCnt++; $display("FAIL wr_mstat: got %h want %h", m_stat, 3'd1); end
      cmpCnt++; if (m_valM !== 64'h0) begin errCnt++; $display("FAIL wr_noread: got %h want %h", m_valM, 64'h0); end
      step();
      set_m(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h3);
      cmpCnt++; if (m_valM !== 64'h1122334455667788) begin errCnt++; $display("FAIL rd_valM: got %h want %h", m_valM, 64'h1122334455667788); end
      cmpCnt++; if (m_valM[7:0] !== 8'h88) begin errCnt++; $display("FAIL rd_byte0: got %h want %h", m_valM[7:0], 8'h88); end
      step();
      cmpCnt++; if (W_valM !== 64'h1122334455667788) begin errCnt++; $display("FAIL W_valM: got %h want %h", W_valM, 64'h1122334455667788); end
      cmpCnt++; if (W_icode !== 4'h5) begin errCnt++; $display("FAIL W_icode_rd: got %h want %h", W_icode, 4'h5); end
      cmpCnt++; if (W_dstM !== 4'h3) begin errCnt++; $display("FAIL W_dstM_rd: got %h want %h", W_dstM, 4'h3); end
      set_m(3'd1, 4'h5, 64'h101, 64'h0, 4'hF, 4'h3);
      cmpCnt++; if (m_valM !== 64'h9911223344556677) begin errCnt++; $display("FAIL rd_unaligned: got %h want %h", m_valM, 64'h9911223344556677); end
      set_m(3'd1, 4'h6, 64'h100, 64'h100, 4'h2, 4'hF);
      cmpCnt++; if (m_valM !== 64'h0) begin errCnt++; $display("FAIL opq_noread: got %h want %h", m_valM, 64'h0); end
      set_idle();
      step();
   endtask

   task automatic test_bounds();
      reset_dut();
      for (int i = 0; i < 8; i++) load_byte(64'h1FF8 + 64'(i), 8'hA5);
      for (int i = 0; i < 8; i++) load_byte(64'h0 + 64'(i), 8'h5A);
      load_byte(64'h2000, 8'hEE);
      set_m(3'd1, 4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0123456789ABCDEF, 4'hF, 4'hF);
      cmpCnt++; if (m_stat !== 3'd3) begin errCnt++; $display("FAIL wr_oob_mstat: got %h want %h", m_stat, 3'd3); end
      step();
      cmpCnt++; if (W_stat !== 3'd3) begin errCnt++; $display("FAIL wr_oob_Wstat: got %h want %h", W_stat, 3'd3); end
      cmpCnt++; if (proc_halt !== 1'b1) begin errCnt++; $display("FAIL wr_oob_halt: got %b want %b", proc_halt, 1'b1); end
      set_m(3'd1, 4'h5, 64'd8184, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_stat !== 3'd1) begin errCnt++; $display("FAIL rd_8184_stat: got %h want %h", m_stat, 3'd1); end
      cmpCnt++; if (m_valM !== 64'hA5A5A5A5A5A5A5A5) begin errCnt++; $display("FAIL rd_8184_val: got %h want %h", m_valM, 64'hA5A5A5A5A5A5A5A5); end
      set_m(3'd1, 4'h5, 64'd0, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'h5A5A5A5A5A5A5A5A) begin errCnt++; $display("FAIL rd_0_val: got %h want %h", m_valM, 64'h5A5A5A5A5A5A5A5A); end
      set_m(3'd1, 4'h5, 64'd8185, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_stat !== 3'd3) begin errCnt++; $display("FAIL rd_8185_stat: got %h want %h", m_stat, 3'd3); end
      cmpCnt++; if (m_valM !== 64'h0) begin errCnt++; $display("FAIL rd_8185_val: got %h want %h", m_valM, 64'h0); end
      set_idle();
   endtask

   task automatic test_exception_gating();
      reset_dut();
      for (int i = 0; i < 8; i++) load_byte(64'h200 + 64'(i), 8'h33);
      set_m(3'd1, 4'h5, 64'd8185, 64'h0, 4'hF, 4'h1);
      step();
      cmpCnt++; if (W_stat !== 3'd3) begin errCnt++; $display("FAIL exc_Wstat: got %h want %h", W_stat, 3'd3); end
      set_m(3'd1, 4'hA, 64'h200, 64'hDEADBEEFCAFEF00D, 4'h4, 4'hF);
      cmpCnt++; if (m_stat !== 3'd1) begin errCnt++; $display("FAIL exc_push_mstat: got %h want %h", m_stat, 3'd1); end
      step();
      set_idle();
      step(); step();
      cmpCnt++; if (W_stat !== 3'd1) begin errCnt++; $display("FAIL exc_nop_Wstat: got %h want %h", W_stat, 3'd1); end
      cmpCnt++; if (proc_halt !== 1'b1) begin errCnt++; $display("FAIL exc_sticky: got %b want %b", proc_halt, 1'b1); end
      set_m(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'h3333333333333333) begin errCnt++; $display("FAIL exc_push_blocked: got %h want %h", m_valM, 64'h3333333333333333); end
      reset_dut();
      set_m(3'd4, 4'h4, 64'h200, 64'h1111111111111111, 4'hF, 4'hF);
      step();
      reset_dut();
      set_m(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'h3333333333333333) begin errCnt++; $display("FAIL exc_ins_blocked: got %h want %h", m_valM, 64'h3333333333333333); end
      for (int i = 0; i < 8; i++) load_byte(64'h300 + 64'(i), 8'h44);
      set_m(3'd1, 4'h4, 64'h300, 64'h9999999999999999, 4'hF, 4'hF);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      set_m(3'd1, 4'h5, 64'h300, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'h4444444444444444) begin errCnt++; $display("FAIL rst_write_dropped: got %h want %h", m_valM, 64'h4444444444444444); end
      set_m(3'd1, 4'hA, 64'h200, 64'hDEADBEEFCAFEF00D, 4'h4, 4'hF);
      step();
      set_m(3'd1, 4'h8, 64'h208, 64'h0000000000001234, 4'h4, 4'hF);
      step();
      set_m(3'd1, 4'h5, 64'h200, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'hDEADBEEFCAFEF00D) begin errCnt++; $display("FAIL push_ok: got %h want %h", m_valM, 64'hDEADBEEFCAFEF00D); end
      set_m(3'd1, 4'h5, 64'h208, 64'h0, 4'hF, 4'h1);
      cmpCnt++; if (m_valM !== 64'h0000000000001234) begin errCnt++; $display("FAIL call_ok: got %h want %h", m_valM, 64'h0000000000001234); end
      cmpCnt++; if (proc_halt !== 1'b0) begin errCnt++; $display("FAIL push_ok_halt: got %b want %b", proc_halt, 1'b0); end
      set_idle();
   endtask

   task automatic test_ret_source();
      reset_dut();
      load_byte(64'h40, 8'h1F);
      for (int i = 1; i < 8; i++) load_byte(64'h40 + 64'(i), 8'h00);
      set_m(3'd1, 4'h9, 64'h999, 64'h40, 4'h4, 4'hF);
      cmpCnt++; if (m_valM !== 64'h1F) begin errCnt++; $display("FAIL ret_valM: got %h want %h", m_valM, 64'h1F); end
      cmpCnt++; if (m_stat !== 3'd1) begin errCnt++; $display("FAIL ret_mstat: got %h want %h", m_stat, 3'd1); end
      set_m(3'd1, 4'hB, 64'h999, 64'h40, 4'h4, 4'h2);
      cmpCnt++; if (m_valM !== 64'h1F) begin errCnt++; $display("FAIL pop_valM: got %h want %h", m_valM, 64'h1F); end
      set_idle();
   endtask

   task automatic test_stall();
      reset_dut();
      set_m(3'd1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h3);
      step();
      cmpCnt++; if (W_icode !== 4'h5) begin errCnt++; $display("FAIL stall_pre_icode: got %h want %h", W_icode, 4'h5); end
      W_stall = 1'b1;
      set_m(3'd1, 4'h6, 64'h55, 64'h0, 4'h4, 4'hF);
      step();
      cmpCnt++; if (W_icode !== 4'h5) begin errCnt++; $display("FAIL stall1_icode: got %h want %h", W_icode, 4'h5); end
      cmpCnt++; if (W_valM !== 64'h1122334455667788) begin errCnt++; $display("FAIL stall1_valM: got %h want %h", W_valM, 64'h1122334455667788); end
      step();
      cmpCnt++; if (W_icode !== 4'h5) begin errCnt++; $display("FAIL stall2_icode: got %h want %h", W_icode, 4'h5); end
      cmpCnt++; if (W_dstM !== 4'h3) begin errCnt++; $display("FAIL stall2_dstM: got %h want %h", W_dstM, 4'h3); end
      cmpCnt++; if (W_valE !== 64'h100) begin errCnt++; $display("FAIL stall2_valE: got %h want %h", W_valE, 64'h100); end
      W_stall = 1'b0;
      step();
      cmpCnt++; if (W_icode !== 4'h6) begin errCnt++; $display("FAIL unstall_icode: got %h want %h", W_icode, 4'h6); end
      cmpCnt++; if (W_valE !== 64'h55) begin errCnt++; $display("FAIL unstall_valE: got %h want %h", W_valE, 64'h55); end
      cmpCnt++; if (W_valM !== 64'h0) begin errCnt++; $display("FAIL unstall_valM: got %h want %h", W_valM, 64'h0); end
      cmpCnt++; if (W_dstE !== 4'h4) begin errCnt++; $display("FAIL unstall_dstE: got %h want %h", W_dstE, 4'h4); end
      set_idle();
   endtask

   initial begin
      rst_n = 1'b1;
      W_stall = 1'b0;
      ld_en = 1'b0; ld_addr = 64'h0; ld_data = 8'h0;
      set_idle();
      test_reset();
      test_write_read();
      test_bounds();
      test_exception_gating();
      test_ret_source();
      test_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus M→W pipeline register for the Y86-64 pipelined processor; sits between the M register (memory_reg outputs) and the register-file write-back.
- Contains the byte-addressed data memory, address/data/read/write selection, memory-error status generation, the W pipeline register and a sticky halt flag.
- Its combinational outputs feed the decode forwarding network and pipeline control.

Parameters:
- DMEM_BYTES, 8192, data-memory size in bytes; legal 8-byte accesses are addr .. addr+7 < DMEM_BYTES.
- AOK, 3'd1, status code: normal.
- HLT, 3'd2, status code: halt.
- ADR, 3'd3, status code: address error.
- INS, 3'd4, status code: invalid instruction.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- M_stat  in  3  status from M register.
- M_icode  in  4  icode from M register.
- M_valE  in  64  ALU result.
- M_valA  in  64  forwarded valA; also the return address for call.
- M_dstE  in  4  destination register for valE.
- M_dstM  in  4  destination register for valM.
- W_stall  in  1  from pipeline control; hold W register.
- ld_en  in  1  preload write enable, bench/loader use only.
- ld_addr  in  64  preload byte address.
- ld_data  in  8  preload byte.
- m_stat  out  3  memory-stage status, combinational.
- m_valM  out  64  memory read data, combinational; used for forwarding.
- W_stat  out  3  registered status.
- W_icode  out  4  registered icode.
- W_valE  out  64  registered valE.
- W_valM  out  64  registered valM.
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.
- proc_halt  out  1  sticky: W_stat has left AOK.

Behaviour:
- Address select:
  - rmmovq (4), mrmovq (5), pushq (A), call (8): M_valE.
  - popq (B), ret (9): M_valA.
  - All other icodes: 0.
- Read when icode ∈ {5, B, 9}. Write when icode ∈ {4, A, 8}. Write data is always M_valA.
- Reads are combinational, 8 bytes, little-endian: m_valM = mem[a+7]..mem[a].
  - m_valM = 0 when there is no read or dmem_error is set.
- dmem_error = (read|write) && (addr > DMEM_BYTES-8). Compute with 64-bit unsigned compare; never evaluate a+7, so no wrap-around.
- m_stat = ADR if dmem_error, else M_stat.
- Write commit (rising edge): all 8 bytes are written, little-endian, only if all of these hold:
  - write is set and dmem_error is clear;
  - M_stat == AOK;
  - W_stat == AOK;
  - proc_halt == 0.
  - An instruction already carrying an exception, or following one, never modifies memory.
- Partial writes never occur: an out-of-range write changes no byte.
- ld_en writes ld_data to mem[ld_addr] on the edge when ld_addr < DMEM_BYTES; otherwise it is ignored.
- Simultaneous ld_en and a pipeline write to the same byte: pipeline data wins.
- W register:
  - On each edge with W_stall = 0: W_* ← {m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM}.
  - W_stall = 1: hold all W_* values.
- proc_halt:
  - Set on the first edge after which W_stat != AOK.
  - Cleared only by reset; ignores W_stall.
- Reset (rst_n = 0, asynchronous) forces the W register to bubble and clears proc_halt:
  - W_stat = AOK, W_icode = 1 (nop), W_valE = 0, W_valM = 0, W_dstE = F, W_dstM = F, proc_halt = 0.
  - Memory contents are not cleared.
- Reset mid-write: if rst_n is low at the edge, the write is dropped.
- Latency: memory results are visible on m_* in the same cycle and on W_* one cycle later.

Decomposition:
- Shared package/include y86_defs:
  - icode constants: HALT, NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - stat codes: AOK, HLT, ADR, INS.
  - RNONE = 4'hF.
- One natural sub-module: data_memory. It holds the byte array, the combinational 8-byte read, the gated 8-byte write, the preload port and the bounds check.
- Address/control selection and the W register stay in mem_wb_stage.

Test Plan:
- Reset: rst_n = 0 mid-cycle → W_icode = 1, W_stat = 1, W_dstE = W_dstM = F, proc_halt = 0, all asserted immediately, before any clock edge.
- Write then read:
  - rmmovq: icode = 4, M_valE = 0x100, M_valA = 0x1122334455667788.
  - Next cycle, mrmovq: icode = 5, M_valE = 0x100.
  - Expect m_valM = 0x1122334455667788 and mem[0x100] = 0x88.
  - Expect W_valM equal to that value one edge later.
- Bounds:
  - mrmovq at M_valE = 8184 → m_stat = AOK.
  - mrmovq at M_valE = 8185 → m_stat = ADR, m_valM = 0.
  - rmmovq at M_valE = 0xFFFFFFFFFFFFFFFC → m_stat = ADR, memory unchanged.
- Exception gating:
  - With W_stat = ADR in the W register, a pushq to M_valE = 0x200 writes nothing.
  - proc_halt = 1 and stays 1 after a further AOK instruction.
- ret/popq source: icode = 9, M_valA = 0x40, M_valE = 0x999, mem[0x40..0x47] preloaded with 0x1F → m_valM = 0x1F (reads the M_valA address).
- Stall: W_stall = 1 for 2 cycles while M_icode changes 5→6 → W_* stay frozen at the mrmovq values; after release, W_icode = 6.
